// File: rtl/signed_sum_capture_pkg.sv
// Shared types and helpers for the signed adder output capture stage.
// The entry record is sized by DEFAULT_WIDTH; the top's WIDTH must match it.
package signed_sum_capture_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [DEFAULT_WIDTH-1:0] SAT_POS = {1'b0, {(DEFAULT_WIDTH-1){1'b1}}};
    localparam logic [DEFAULT_WIDTH-1:0] SAT_NEG = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] data;
        logic                     ovf;
        logic                     carry;
    } entry_t;

    // Two's-complement overflow: like-signed operands producing an opposite-signed sum.
    function automatic logic ovf_detect(input logic a_msb, input logic b_msb, input logic sum_msb);
        return (a_msb == b_msb) && (sum_msb != a_msb);
    endfunction

endpackage

// File: rtl/sum_skid_fifo.sv
// Two-entry FIFO of entry_t records with 1-bit wrapping pointers.
// Pushes while full and pops while empty are ignored.
module sum_skid_fifo
    import signed_sum_capture_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  entry_t     wr_entry,
    input  logic       pop,
    output entry_t     rd_entry,
    output logic       full,
    output logic       empty,
    output logic [1:0] occupancy
);

    entry_t     mem_reg [2];
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic       push_ok;
    logic       pop_ok;

    assign full      = (count_reg == 2'd2);
    assign empty     = (count_reg == 2'd0);
    assign occupancy = count_reg;
    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty;
    assign rd_entry  = mem_reg[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (push_ok && (wr_ptr_reg == 1'(gi))) begin
                    mem_reg[gi] <= wr_entry;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop_ok)  rd_ptr_reg <= ~rd_ptr_reg;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/signed_sum_capture.sv
// Registered capture stage behind the signed adder: overflow detect, optional
// saturation, 2-deep output buffer and a saturating overflow-event counter.
module signed_sum_capture
    import signed_sum_capture_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 a_msb,
    input  logic                 b_msb,
    input  logic [WIDTH-1:0]     sum,
    input  logic                 cout,
    input  logic                 sat_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_ovf,
    output logic                 out_carry,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] ovf_count
);

    logic                 ovf;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [1:0]           unused_occupancy;
    entry_t               wr_entry;
    entry_t               head;
    logic [CNT_WIDTH-1:0] ovf_count_reg;

    assign ovf       = ovf_detect(a_msb, b_msb, sum[WIDTH-1]);
    assign in_ready  = ~full & ~rst;
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Saturation is resolved before storage so later sat_en changes cannot touch buffered data.
    always_comb begin
        wr_entry.data  = sum;
        if (sat_en && ovf) begin
            wr_entry.data = a_msb ? SAT_NEG : SAT_POS;
        end
        wr_entry.ovf   = ovf;
        wr_entry.carry = cout;
    end

    sum_skid_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .wr_entry  (wr_entry),
        .pop       (pop),
        .rd_entry  (head),
        .full      (full),
        .empty     (empty),
        .occupancy (unused_occupancy)
    );

    assign out_data  = out_valid ? head.data  : '0;
    assign out_ovf   = out_valid ? head.ovf   : 1'b0;
    assign out_carry = out_valid ? head.carry : 1'b0;

    // Clear has priority over a same-cycle overflow increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count_reg <= '0;
        end else if (cnt_clr) begin
            ovf_count_reg <= '0;
        end else if (push && ovf && !(&ovf_count_reg)) begin
            ovf_count_reg <= ovf_count_reg + CNT_WIDTH'(1);
        end
    end

    assign ovf_count = ovf_count_reg;

endmodule

// File: doc/signed_sum_capture.md
Name: signed_sum_capture

Overview:
- Registered output stage placed directly downstream of the 16-bit combinational signed adder.
- Captures each adder result (Sum, Cout, operand sign bits) under a valid/ready handshake.
- Detects two's-complement overflow and optionally saturates the result.
- Buffers results in a 2-entry FIFO and keeps a saturating overflow-event counter for software/debug visibility.

Parameters:
- WIDTH, 16: data width of sum and operands; must match the adder.
- CNT_WIDTH, 16: width of the overflow-event counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  adder result presented this cycle.
- in_ready  out  1  stage can accept a result.
- a_msb  in  1  bit WIDTH-1 of adder operand A.
- b_msb  in  1  bit WIDTH-1 of adder operand B.
- sum  in  WIDTH  adder Sum.
- cout  in  1  adder Cout.
- sat_en  in  1  1 = saturate on overflow; 0 = wrap (pass sum unchanged). Sampled with each accepted beat.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head entry.
- out_data  out  WIDTH  head result (saturated or wrapped).
- out_ovf  out  1  head result overflowed.
- out_carry  out  1  head result's cout.
- cnt_clr  in  1  synchronous clear of ovf_count.
- ovf_count  out  CNT_WIDTH  number of accepted overflowing beats, saturating.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - FIFO occupancy = 0, read/write pointers = 0, entries = 0, ovf_count = 0.
  - out_valid = 0, out_data = 0, out_ovf = 0, out_carry = 0.
  - in_ready is forced 0 while rst is high.
  - Reset mid-transfer discards all buffered entries; nothing is replayed.
- Push: in_valid & in_ready at a rising edge. Pop: out_valid & out_ready at a rising edge.
- Overflow is computed combinationally on the input beat: ovf = (a_msb == b_msb) & (sum[WIDTH-1] != a_msb).
- Stored data:
  - If sat_en & ovf: a_msb = 0 stores 0x7FFF (max positive); a_msb = 1 stores 0x8000 (min negative). Generalise by WIDTH.
  - Otherwise stores sum unchanged.
  - The entry also stores ovf and cout.
- Ready/valid signals:
  - in_ready = (occupancy < 2) and not rst. There is no combinational path from out_ready to in_ready.
  - out_valid = (occupancy != 0).
  - out_data, out_ovf and out_carry show the head entry when out_valid = 1, and are forced 0 when out_valid = 0.
- Latency: a beat pushed at edge N appears on the outputs after edge N (1 cycle). There is no input-to-output combinational bypass.
- Simultaneous push and pop:
  - Occupancy 1: occupancy stays 1; the new entry becomes head after the pop.
  - Occupancy 2: in_ready = 0, so no push; the pop brings occupancy to 1.
  - Occupancy 0: pop is impossible (out_valid = 0); push brings occupancy to 1.
- Pointers are 1-bit and wrap modulo 2. Order is strictly FIFO.
- ovf_count:
  - Increments by 1 on each push with ovf = 1, regardless of sat_en.
  - Holds at all-ones; no wrap.
  - cnt_clr = 1 sets it to 0 at the next edge. Clear wins over a simultaneous increment.
- Data held in the FIFO is never modified by later sat_en changes.

Decomposition:
- Shared package:
  - WIDTH default constant.
  - SAT_POS and SAT_NEG constants, derived from WIDTH.
  - Entry record/struct type {data, ovf, carry}.
  - Overflow-detect function.
- One sub-module: sum_skid_fifo. It is a generic 2-entry FIFO of the entry type with push/pop, full/empty, occupancy and async reset.
- The top level holds the overflow/saturation logic, output masking and the counter.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> in_ready = 0 during rst, then 1; out_valid = 0, out_data = 0x0000, ovf_count = 0.
- Positive overflow, saturate: a_msb = 0, b_msb = 0, sum = 0x8000, cout = 0, sat_en = 1 -> next cycle out_data = 0x7FFF, out_ovf = 1, out_carry = 0, ovf_count = 1.
- Negative overflow, wrap: a_msb = 1, b_msb = 1, sum = 0x7FFF, cout = 1, sat_en = 0 -> out_data = 0x7FFF, out_ovf = 1, out_carry = 1, ovf_count increments.
- No overflow, mixed signs:
  - a_msb = 0, b_msb = 1, sum = 0xFFFE, sat_en = 1 -> out_data = 0xFFFE, out_ovf = 0.
  - Same-sign case sum = 0x0003 (A = 1, B = 2) -> out_ovf = 0.
- Backpressure/full:
  - Hold out_ready = 0, push 0x0001 and 0x0002 -> in_ready = 0 after the second push, third beat 0x0003 stalls.
  - Then raise out_ready -> outputs 0x0001, 0x0002, 0x0003 in order, with push and pop in the same cycle at occupancy 1.
- Counter edges:
  - Preload by 0xFFFF overflowing beats -> ovf_count holds 0xFFFF.
  - cnt_clr together with an overflowing push -> ovf_count = 0.
  - Reset with 2 entries buffered -> out_valid = 0 immediately; the entries are never emitted.
